// File: rtl/micro_host_pkg.sv
// Shared types and default widths for the pairing-accelerator host-port sequencer.
package micro_host_pkg;

    localparam int DEF_FUNCIDW  = 8;
    localparam int DEF_CORELOG2 = 2;
    localparam int DEF_RFSZLOG2 = 4;
    localparam int DEF_WORDSZ   = 16;

    typedef enum logic [1:0] {
        OP_WR    = 2'b00,
        OP_RD    = 2'b01,
        OP_START = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_WAIT,
        RSP,
        STRT,
        WAIT_HI,
        WAIT_LO
    } state_e;

    // Bits needed to hold the value n (at least one).
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/micro_host_seq.sv
// Host-port initiator: turns a valid/ready command stream into register-file
// writes/reads and job starts on the accelerator port, returning read data and job completion.
module micro_host_seq
    import micro_host_pkg::*;
#(
    parameter int FUNCIDW  = DEF_FUNCIDW,
    parameter int CORELOG2 = DEF_CORELOG2,
    parameter int RFSZLOG2 = DEF_RFSZLOG2,
    parameter int WORDSZ   = DEF_WORDSZ,
    parameter int RD_LAT   = 1,
    parameter int START_TO = 16
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [CORELOG2-1:0] cmd_chip,
    input  logic [RFSZLOG2-1:0] cmd_addr,
    input  logic [WORDSZ-1:0]   cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSZ-1:0]   rsp_data,
    output logic                done,
    output logic                err_start,
    output logic [FUNCIDW-1:0]  funcid,
    output logic                start,
    output logic                wen,
    output logic [CORELOG2-1:0] chip_sel,
    output logic [RFSZLOG2-1:0] waddr,
    output logic [WORDSZ-1:0]   wdata,
    output logic                ren,
    output logic [RFSZLOG2-1:0] raddr,
    input  logic [WORDSZ-1:0]   rdata,
    input  logic                busy
);

    localparam int RDCW = cnt_w(RD_LAT);
    localparam int TOCW = cnt_w(START_TO);
    localparam logic [RDCW-1:0] RD_LAST = RDCW'(RD_LAT - 1);
    localparam logic [TOCW-1:0] TO_MAX  = TOCW'(START_TO);

    state_e          state;
    state_e          state_nxt;
    op_e             op;
    logic            accept;
    logic            rd_sample;
    logic            to_expire;
    logic [RDCW-1:0] rd_cnt;
    logic [TOCW-1:0] to_cnt;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state == IDLE) && !busy && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RSP);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        rd_sample = 1'b0;
        to_expire = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_WR:    state_nxt = WR;
                        OP_RD:    state_nxt = RD_WAIT;
                        OP_START: state_nxt = STRT;
                        default:  state_nxt = IDLE;
                    endcase
                end
            end
            WR:      state_nxt = IDLE;
            RD_WAIT: begin
                if (rd_cnt == RD_LAST) begin
                    rd_sample = 1'b1;
                    state_nxt = RSP;
                end
            end
            RSP:     if (rsp_ready) state_nxt = IDLE;
            STRT:    state_nxt = WAIT_HI;
            WAIT_HI: begin
                // busy wins over a timeout landing on the same cycle
                if (busy) begin
                    state_nxt = WAIT_LO;
                end else if (to_cnt >= TO_MAX) begin
                    to_expire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_LO: if (!busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state is updated with non-blocking assignments.
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            to_cnt    <= '0;
            wen       <= 1'b0;
            ren       <= 1'b0;
            start     <= 1'b0;
            done      <= 1'b0;
            err_start <= 1'b0;
            chip_sel  <= '0;
            waddr     <= '0;
            wdata     <= '0;
            raddr     <= '0;
            funcid    <= '0;
            rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            wen   <= accept && (op == OP_WR);
            ren   <= accept && (op == OP_RD);
            start <= accept && (op == OP_START);
            done  <= (state == WAIT_LO) && !busy;

            if (to_expire) err_start <= 1'b1;
            if (rd_sample) rsp_data <= rdata;

            // chip_sel only follows register-file commands; START leaves it untouched
            if (accept) begin
                case (op)
                    OP_WR: begin
                        chip_sel <= cmd_chip;
                        waddr    <= cmd_addr;
                        wdata    <= cmd_data;
                    end
                    OP_RD: begin
                        chip_sel <= cmd_chip;
                        raddr    <= cmd_addr;
                    end
                    OP_START: funcid <= cmd_data[FUNCIDW-1:0];
                    default: ;
                endcase
            end

            rd_cnt <= (state == RD_WAIT) ? rd_cnt + 1'b1 : '0;

            case (state)
                STRT:    to_cnt <= TOCW'(1);
                WAIT_HI: if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
                default: to_cnt <= '0;
            endcase
        end
    end

endmodule

// File: doc/micro_host_seq.md
Name: micro_host_seq

Overview:
- Host-side initiator for the pairing accelerator's host port: chip_sel, register-file write/read, funcid and start, with busy as the return signal.
- Accepts a valid/ready command stream of WRITE, READ, START and NOP operations and sequences them onto that port with the port's timing rules.
- Returns read data on a valid/ready response stream and signals job completion.
- Sits between the SoC or test host and the accelerator top.

Parameters:
- FUNCIDW, default `FUNCIDW: function-id width.
- CORELOG2, default `CORELOG2: core-select width.
- RFSZLOG2, default `RFSZLOG2: register-file address width.
- WORDSZ, default `WORDSZ: data word width.
- RD_LAT, default 1: cycles from ren asserted to rdata valid.
- START_TO, default 16: cycles allowed for busy to rise after start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 WRITE, 01 READ, 10 START, 11 NOP
- cmd_chip  in  CORELOG2  target core
- cmd_addr  in  RFSZLOG2  register-file address
- cmd_data  in  WORDSZ  write data; for START, bits [FUNCIDW-1:0] carry the funcid
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  response consumer ready
- rsp_data  out  WORDSZ  read data
- done  out  1  one-cycle pulse when a started job finishes
- err_start  out  1  sticky; busy failed to rise within START_TO cycles
- funcid  out  FUNCIDW  to accelerator
- start  out  1  to accelerator
- wen  out  1  to accelerator
- chip_sel  out  CORELOG2  to accelerator
- waddr  out  RFSZLOG2  to accelerator
- wdata  out  WORDSZ  to accelerator
- ren  out  1  to accelerator
- raddr  out  RFSZLOG2  to accelerator
- rdata  in  WORDSZ  from accelerator
- busy  in  1  from accelerator

Behaviour:
- Reset: every registered output is 0. FSM goes to IDLE, counters clear, err_start clears, and any pending response is dropped. Reset takes priority over every other event, including in the middle of a job or a handshake.
- cmd_ready = (state==IDLE) & ~busy & ~rst, combinational. No command is accepted while the accelerator is busy.
- FSM states: IDLE, WR, RD_WAIT, RSP, STRT, WAIT_HI, WAIT_LO.
- WRITE accepted at cycle t: state WR at t+1. wen=1 for exactly one cycle at t+1, with chip_sel, waddr and wdata registered from the command. Returns to IDLE at t+2.
- READ accepted at cycle t:
  - ren=1 for one cycle at t+1 with chip_sel and raddr.
  - State RD_WAIT; chip_sel is held stable until rdata is sampled, at the end of cycle t+RD_LAT.
  - rsp_data is loaded and rsp_valid=1 from t+1+RD_LAT in state RSP.
  - rsp_valid and rsp_data hold until rsp_ready; on that handshake, rsp_valid drops the next cycle and the FSM returns to IDLE.
  - Consequence: a read completes in at least RD_LAT+2 cycles.
- START accepted at cycle t:
  - start=1 for one cycle at t+1, with funcid = cmd_data[FUNCIDW-1:0] held until the job ends.
  - State WAIT_HI; a timeout counter counts cycles since the start pulse.
  - busy=1 moves to WAIT_LO.
  - If START_TO cycles pass without busy, err_start is set and the FSM returns to IDLE with no done pulse.
  - In WAIT_LO, busy falling produces done=1 for one cycle and the FSM returns to IDLE.
- NOP: accepted and consumed with no port activity; the FSM stays in IDLE.
- Between commands, wen, ren and start are 0. waddr, wdata, raddr and chip_sel hold their last values.
- busy rising while in IDLE with no start (external start): cmd_ready stays low and no done pulse is generated.
- err_start is cleared only by rst; later commands proceed normally.
- Widths: the funcid slice is a truncation with no check. The timeout counter is $clog2(START_TO+1) bits and saturates.

Decomposition:
- Package micro_host_pkg: op_e enum (OP_WR, OP_RD, OP_START, OP_NOP) and state_e enum.
- Widths come from the existing params headers.
- No sub-module; a single FSM with two small counters is sufficient.

Test Plan:
- WRITE chip=1, addr=5, data=0xA5 accepted at t -> wen=1 only at t+1 with chip_sel=1, waddr=5, wdata=0xA5; cmd_ready=1 again at t+2.
- READ chip=2, addr=3 with RD_LAT=1, memory word 0x1234, rsp_ready held low 3 cycles -> ren pulses at t+1; rsp_valid from t+2 holds 0x1234 until the handshake; chip_sel stays 2 throughout.
- START with cmd_data=0x7; model raises busy at t+2 and drops it at t+20 -> start pulse at t+1, funcid=7, cmd_ready=0 throughout, done pulse one cycle after busy falls, err_start=0.
- START where busy never rises, START_TO=16 -> err_start=1 after 16 cycles, FSM in IDLE, no done pulse, the next WRITE executes.
- cmd_valid held high while busy=1 from an external source -> no wen/ren/start, cmd_ready=0; the command is accepted the first cycle busy=0.
- rst asserted during RSP, with rsp_valid=1 and rsp_ready=0 -> next cycle rsp_valid=0, all outputs 0, cmd_ready=1 once rst is low and busy=0.
